load_store_queue_ooo: RTL and testbench

Parametrised second-generation load/store queue that sits between rename/read and the data-cache port in the exe stage. It allocates memory ops in program order and translates them one at a time through the dTLB. Stores issue in order once the ROB commits them. Loads issue out of order past older non-conflicting stores, with optional store-to-load forwarding.

---
 rtl/load_store_queue_ooo.sv | 193 +++++++++++++++++++
 tb/tb_load_store_queue_ooo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_queue_ooo.sv
// Out-of-order load/store queue: in-order alloc and translate, in-order committed stores,
// loads bypass older non-conflicting stores. Define LSQ_LD_FWD_EN for store-to-load forwarding.
module load_store_queue_ooo #(
  parameter int DEPTH  = 8,
  parameter int VA_W   = 39,
  parameter int PA_W   = 40,
  parameter int DATA_W = 64,
  parameter int GIDX_W = 6
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  input  logic                       alloc_valid_i,
  output logic                       alloc_ready_o,
  input  logic                       alloc_is_store_i,
  input  logic [1:0]                 alloc_size_i,
  input  logic [VA_W-1:0]            alloc_vaddr_i,
  input  logic [DATA_W-1:0]          alloc_data_i,
  input  logic [GIDX_W-1:0]          alloc_gidx_i,
  output logic                       tlb_req_valid_o,
  output logic [VA_W-13:0]           tlb_req_vpn_o,
  output logic                       tlb_req_store_o,
  input  logic                       tlb_resp_valid_i,
  input  logic [PA_W-13:0]           tlb_resp_ppn_i,
  input  logic                       tlb_resp_fault_i,
  input  logic                       commit_valid_i,
  input  logic [GIDX_W-1:0]          commit_gidx_i,
  output logic                       mem_valid_o,
  input  logic                       mem_ready_i,
  output logic                       mem_is_store_o,
  output logic [1:0]                 mem_size_o,
  output logic [PA_W-1:0]            mem_paddr_o,
  output logic [DATA_W-1:0]          mem_data_o,
  output logic [GIDX_W-1:0]          mem_gidx_o,
  output logic [1:0]                 mem_xcpt_o,
  output logic                       fwd_valid_o,
  output logic [DATA_W-1:0]          fwd_data_o,
  output logic [GIDX_W-1:0]          fwd_gidx_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0]   ptr_t;
  typedef logic [AW-1:0] idx_t;

  typedef struct packed {
    logic              is_store;
    logic [1:0]        size;
    logic [PA_W-1:0]   addr;   // holds the vaddr until translated
    logic [DATA_W-1:0] data;
    logic [GIDX_W-1:0] gidx;
    logic [1:0]        xcpt;
  } entry_t;

  entry_t             ent [DEPTH];
  logic [DEPTH-1:0]   valid, xlated, done;
  ptr_t               head, tail, xl_ptr;   // extra MSB separates full from empty
  idx_t               h, x, t, sel, ld_idx, fwd_src, li, sj, src;
  logic               alloc_fire, mis, xl_adv, retire, head_xcpt, head_st, head_go, mem_fire;
  logic               ld_found, ld_fwd, ok, conf, match;

  assign h  = head[AW-1:0];
  assign x  = xl_ptr[AW-1:0];
  assign t  = tail[AW-1:0];

  assign count_o       = tail - head;
  assign empty_o       = (count_o == '0);
  assign full_o        = (count_o == ptr_t'(DEPTH));
  assign alloc_ready_o = rstn_i & !full_o & !flush_i;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;

  always_comb begin
    case (alloc_size_i)
      2'd0:    mis = 1'b0;
      2'd1:    mis = alloc_vaddr_i[0];
      2'd2:    mis = |alloc_vaddr_i[1:0];
      default: mis = |alloc_vaddr_i[2:0];
    endcase
  end

  assign tlb_req_valid_o = (xl_ptr != tail) & !xlated[x];
  assign tlb_req_vpn_o   = tlb_req_valid_o ? ent[x].addr[VA_W-1:12] : '0;
  assign tlb_req_store_o = tlb_req_valid_o & ent[x].is_store;
  assign xl_adv          = (xl_ptr != tail) & (xlated[x] | tlb_resp_valid_i);

  assign head_xcpt = valid[h] & !done[h] & (ent[h].xcpt != 2'd0);
  assign head_st   = valid[h] & !done[h] & ent[h].is_store & xlated[h] & (ent[h].xcpt == 2'd0) &
                     commit_valid_i & (commit_gidx_i == ent[h].gidx);
  assign head_go   = head_xcpt | head_st;

  // Oldest eligible load; the inner scan keeps the youngest older conflicting store.
  always_comb begin
    ld_found = 1'b0; ld_idx = '0; ld_fwd = 1'b0; fwd_src = '0;
    li = '0; sj = '0; src = '0; ok = 1'b0; conf = 1'b0; match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      li = h + idx_t'(i);
      if (!ld_found && valid[li] && !ent[li].is_store && xlated[li] && !done[li] &&
          ent[li].xcpt == 2'd0) begin
        ok = 1'b1; conf = 1'b0; match = 1'b0; src = '0;
        for (int j = 0; j < i; j++) begin
          sj = h + idx_t'(j);
          if (valid[sj] && ent[sj].is_store && !done[sj]) begin
            if (!xlated[sj]) ok = 1'b0;
            else if (ent[sj].addr[PA_W-1:3] == ent[li].addr[PA_W-1:3]) begin
              conf  = 1'b1;
              match = (ent[sj].addr == ent[li].addr) && (ent[sj].size == ent[li].size);
              src   = sj;
            end
          end
        end
`ifdef LSQ_LD_FWD_EN
        if (ok && (!conf || match)) begin
          ld_found = 1'b1; ld_idx = li; ld_fwd = conf; fwd_src = src;
        end
`else
        if (ok && !conf) begin
          ld_found = 1'b1; ld_idx = li;
        end
`endif
      end
    end
  end

  assign sel         = head_go ? h : ld_idx;
  assign mem_valid_o = !flush_i & (head_go | (ld_found & !ld_fwd));
  assign mem_fire    = mem_valid_o & mem_ready_i;
  assign mem_is_store_o = mem_valid_o & ent[sel].is_store;
  assign mem_size_o  = mem_valid_o ? ent[sel].size : '0;
  assign mem_paddr_o = mem_valid_o ? ent[sel].addr : '0;
  assign mem_data_o  = mem_valid_o ? ent[sel].data : '0;
  assign mem_gidx_o  = mem_valid_o ? ent[sel].gidx : '0;
  assign mem_xcpt_o  = mem_valid_o ? ent[sel].xcpt : '0;

`ifdef LSQ_LD_FWD_EN
  logic [DATA_W-1:0] fwd_mask;
  always_comb begin
    case (ent[fwd_src].size)
      2'd0:    fwd_mask = DATA_W'(8'hFF);
      2'd1:    fwd_mask = DATA_W'(16'hFFFF);
      2'd2:    fwd_mask = DATA_W'(32'hFFFF_FFFF);
      default: fwd_mask = '1;
    endcase
  end
  assign fwd_valid_o = !flush_i & ld_found & ld_fwd & !head_go;
  assign fwd_data_o  = fwd_valid_o ? (ent[fwd_src].data & fwd_mask) : '0;
  assign fwd_gidx_o  = fwd_valid_o ? ent[ld_idx].gidx : '0;
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_data_o  = '0;
  assign fwd_gidx_o  = '0;
`endif

  assign retire = valid[h] & done[h];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid <= '0; xlated <= '0; done <= '0;
      head <= '0; tail <= '0; xl_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush_i) begin
      valid <= '0;
      head <= '0; tail <= '0; xl_ptr <= '0;
    end else begin
      if (alloc_fire) begin
        valid[t]         <= 1'b1;
        xlated[t]        <= mis;
        done[t]          <= 1'b0;
        ent[t].is_store  <= alloc_is_store_i;
        ent[t].size      <= alloc_size_i;
        ent[t].addr      <= PA_W'(alloc_vaddr_i);
        ent[t].data      <= alloc_data_i;
        ent[t].gidx      <= alloc_gidx_i;
        ent[t].xcpt      <= mis ? 2'd1 : 2'd0;
        tail             <= tail + ptr_t'(1);
      end
      if (xl_adv) begin
        if (!xlated[x]) begin
          ent[x].addr <= {tlb_resp_ppn_i, ent[x].addr[11:0]};
          xlated[x]   <= 1'b1;
          if (tlb_resp_fault_i) ent[x].xcpt <= 2'd2;
        end
        xl_ptr <= xl_ptr + ptr_t'(1);
      end
      if (mem_fire)    done[sel]    <= 1'b1;
      if (fwd_valid_o) done[ld_idx] <= 1'b1;
      if (retire) begin
        valid[h] <= 1'b0;
        head     <= head + ptr_t'(1);
      end
    end
  end
endmodule

// File: tb/tb_load_store_queue_ooo.sv
// Directed bench for load_store_queue_ooo with an identity-mapped TLB model.
module tb_load_store_queue_ooo;
  localparam int DEPTH = 8, VA_W = 39, PA_W = 40, DATA_W = 64, GIDX_W = 6;
`ifdef LSQ_LD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk_i = 1'b0, rstn_i, flush_i;
  logic alloc_valid_i, alloc_ready_o, alloc_is_store_i;
  logic [1:0] alloc_size_i;
  logic [VA_W-1:0] alloc_vaddr_i;
  logic [DATA_W-1:0] alloc_data_i;
  logic [GIDX_W-1:0] alloc_gidx_i;
  logic tlb_req_valid_o, tlb_req_store_o, tlb_resp_valid_i, tlb_resp_fault_i;
  logic [VA_W-13:0] tlb_req_vpn_o;
  logic [PA_W-13:0] tlb_resp_ppn_i;
  logic commit_valid_i;
  logic [GIDX_W-1:0] commit_gidx_i;
  logic mem_valid_o, mem_ready_i, mem_is_store_o;
  logic [1:0] mem_size_o, mem_xcpt_o;
  logic [PA_W-1:0] mem_paddr_o;
  logic [DATA_W-1:0] mem_data_o, fwd_data_o;
  logic [GIDX_W-1:0] mem_gidx_o, fwd_gidx_o;
  logic fwd_valid_o, empty_o, full_o;
  logic [$clog2(DEPTH):0] count_o;
  logic tlb_en, tlb_fault;
  int ncmp = 0, nerr = 0;

  always #5 clk_i = ~clk_i;

  assign tlb_resp_valid_i = tlb_req_valid_o & tlb_en;
  assign tlb_resp_ppn_i   = (PA_W-12)'(tlb_req_vpn_o);
  assign tlb_resp_fault_i = tlb_fault;

  load_store_queue_ooo #(.DEPTH(DEPTH), .VA_W(VA_W), .PA_W(PA_W), .DATA_W(DATA_W), .GIDX_W(GIDX_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_is_store_i(alloc_is_store_i),
    .alloc_size_i(alloc_size_i), .alloc_vaddr_i(alloc_vaddr_i), .alloc_data_i(alloc_data_i),
    .alloc_gidx_i(alloc_gidx_i), .tlb_req_valid_o(tlb_req_valid_o), .tlb_req_vpn_o(tlb_req_vpn_o),
    .tlb_req_store_o(tlb_req_store_o), .tlb_resp_valid_i(tlb_resp_valid_i), .tlb_resp_ppn_i(tlb_resp_ppn_i),
    .tlb_resp_fault_i(tlb_resp_fault_i), .commit_valid_i(commit_valid_i), .commit_gidx_i(commit_gidx_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_is_store_o(mem_is_store_o),
    .mem_size_o(mem_size_o), .mem_paddr_o(mem_paddr_o), .mem_data_o(mem_data_o), .mem_gidx_o(mem_gidx_o),
    .mem_xcpt_o(mem_xcpt_o), .fwd_valid_o(fwd_valid_o), .fwd_data_o(fwd_data_o), .fwd_gidx_o(fwd_gidx_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic alloc(input logic st, input logic [1:0] sz, input logic [VA_W-1:0] va,
                       input logic [DATA_W-1:0] d, input logic [GIDX_W-1:0] g);
    alloc_is_store_i = st; alloc_size_i = sz; alloc_vaddr_i = va;
    alloc_data_i = d; alloc_gidx_i = g; alloc_valid_i = 1'b1;
    cyc();
    alloc_valid_i = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0; flush_i = 1'b0; alloc_valid_i = 1'b0; alloc_is_store_i = 1'b0;
    alloc_size_i = '0; alloc_vaddr_i = '0; alloc_data_i = '0; alloc_gidx_i = '0;
    commit_valid_i = 1'b0; commit_gidx_i = '0; mem_ready_i = 1'b0;
    tlb_en = 1'b1; tlb_fault = 1'b0;

    // reset state
    #12;
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_alloc_ready", alloc_ready_o, 0);
    chk("rst_tlb_req", tlb_req_valid_o, 0);
    @(negedge clk_i); rstn_i = 1'b1; #1;
    chk("post_rst_ready", alloc_ready_o, 1);
    cyc();

    // flush with three loads queued, one presenting to mem
    alloc(0, 3, 39'h100, '0, 1);
    alloc(0, 3, 39'h108, '0, 2);
    alloc(0, 3, 39'h110, '0, 3);
    #1 chk("fl_count3", count_o, 3);
    chk("fl_pre_mem_valid", mem_valid_o, 1);
    flush_i = 1'b1; #1;
    chk("fl_mem_cancel", mem_valid_o, 0);
    chk("fl_alloc_ready", alloc_ready_o, 0);
    cyc(); flush_i = 1'b0; #1;
    chk("fl_count0", count_o, 0);
    chk("fl_empty", empty_o, 1);

    // load bypasses uncommitted store
    mem_ready_i = 1'b1;
    alloc(1, 3, 39'h1000, 64'h11, 4);
    alloc(0, 3, 39'h2000, '0, 5);
    #1 chk("byp_count2", count_o, 2);
    chk("byp_no_early_issue", mem_valid_o, 0);
    cyc(); #1;
    chk("byp_ld_valid", mem_valid_o, 1);
    chk("byp_ld_is_store", mem_is_store_o, 0);
    chk("byp_ld_gidx", mem_gidx_o, 5);
    chk("byp_ld_paddr", mem_paddr_o, 40'h2000);
    cyc();
    commit_valid_i = 1'b1; commit_gidx_i = 4; #1;
    chk("byp_st_valid", mem_valid_o, 1);
    chk("byp_st_is_store", mem_is_store_o, 1);
    chk("byp_st_paddr", mem_paddr_o, 40'h1000);
    chk("byp_st_data", mem_data_o, 64'h11);
    cyc(); commit_valid_i = 1'b0;
    repeat (3) cyc();
    chk("byp_drained", empty_o, 1);

    // same-dword conflict stalls the load until the store handshakes
    alloc(1, 3, 39'h1008, 64'h22, 6);
    alloc(0, 2, 39'h100C, '0, 7);
    cyc(); #1;
    chk("cf_stall1", mem_valid_o, 0);
    chk("cf_no_fwd", fwd_valid_o, 0);
    cyc(); #1;
    chk("cf_stall2", mem_valid_o, 0);
    commit_valid_i = 1'b1; commit_gidx_i = 6; #1;
    chk("cf_st_valid", mem_valid_o, 1);
    chk("cf_st_paddr", mem_paddr_o, 40'h1008);
    cyc(); commit_valid_i = 1'b0; #1;
    chk("cf_ld_valid", mem_valid_o, 1);
    chk("cf_ld_gidx", mem_gidx_o, 7);
    chk("cf_ld_size", mem_size_o, 2);
    chk("cf_ld_paddr", mem_paddr_o, 40'h100C);
    repeat (3) cyc();
    chk("cf_drained", empty_o, 1);

    // identical address/size: forwarded when enabled, stalls otherwise
    alloc(1, 3, 39'h3000, 64'hDEADBEEF_01234567, 8);
    alloc(0, 3, 39'h3000, '0, 9);
    cyc(); #1;
    chk("fw_valid", fwd_valid_o, FWD);
    chk("fw_data", fwd_data_o, FWD ? 64'hDEADBEEF_01234567 : 64'h0);
    chk("fw_gidx", fwd_gidx_o, FWD ? 9 : 0);
    chk("fw_no_mem", mem_valid_o, 0);
    cyc(); #1;
    chk("fw_pulse_end", fwd_valid_o, 0);
    commit_valid_i = 1'b1; commit_gidx_i = 8; #1;
    chk("fw_st_issue", mem_is_store_o, 1);
    chk("fw_st_gidx", mem_gidx_o, 8);
    cyc(); commit_valid_i = 1'b0; #1;
    chk("fw_ld_mem", mem_valid_o, !FWD);
    repeat (4) cyc();
    chk("fw_drained", empty_o, 1);

    // misaligned load excepts at head
    alloc(0, 2, 39'h1002, '0, 10);
    #1 chk("mis_valid", mem_valid_o, 1);
    chk("mis_xcpt", mem_xcpt_o, 1);
    chk("mis_gidx", mem_gidx_o, 10);
    repeat (3) cyc();

    // TLB fault on a store issues without commit
    tlb_fault = 1'b1;
    alloc(1, 3, 39'h5000, 64'h33, 11);
    #1 chk("flt_req_valid", tlb_req_valid_o, 1);
    chk("flt_req_store", tlb_req_store_o, 1);
    chk("flt_req_vpn", tlb_req_vpn_o, 5);
    cyc(); tlb_fault = 1'b0; #1;
    chk("flt_valid", mem_valid_o, 1);
    chk("flt_is_store", mem_is_store_o, 1);
    chk("flt_xcpt", mem_xcpt_o, 2);
    repeat (3) cyc();
    chk("flt_drained", empty_o, 1);

    // fill, refuse while full even with retire, refill after wrap
    mem_ready_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) alloc(0, 3, VA_W'(39'h100 * (k + 1)), '0, GIDX_W'(20 + k));
    #1 chk("full_flag", full_o, 1);
    chk("full_ready", alloc_ready_o, 0);
    chk("full_count", count_o, DEPTH);
    cyc();
    mem_ready_i = 1'b1; #1;
    chk("full_head_issue", mem_gidx_o, 20);
    cyc(); mem_ready_i = 1'b0;
    alloc_is_store_i = 1'b0; alloc_size_i = 3; alloc_vaddr_i = 39'h900; alloc_gidx_i = 28;
    alloc_valid_i = 1'b1; #1;
    chk("full_refuse_on_retire", alloc_ready_o, 0);
    cyc(); #1;
    chk("full_after_retire", count_o, DEPTH - 1);
    cyc(); alloc_valid_i = 1'b0; #1;
    chk("wrap_count", count_o, DEPTH);
    chk("wrap_full", full_o, 1);
    mem_ready_i = 1'b1;
    repeat (14) cyc();
    chk("wrap_drained", count_o, 0);

    // asynchronous reset mid-stream
    mem_ready_i = 1'b0;
    alloc(0, 3, 39'h700, '0, 30);
    alloc(0, 3, 39'h708, '0, 31);
    #1 rstn_i = 1'b0; #1;
    chk("arst_count", count_o, 0);
    chk("arst_empty", empty_o, 1);
    chk("arst_mem_valid", mem_valid_o, 0);
    @(negedge clk_i); rstn_i = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
